// File: rtl/input_event_capture_pkg.sv
// Shared types and source-id map for the board input capture path.
package peripherals;

    localparam int unsigned NUM_SOURCES = 21;

    localparam logic [4:0] SRC_CENTER  = 5'd0;
    localparam logic [4:0] SRC_UP      = 5'd1;
    localparam logic [4:0] SRC_RIGHT   = 5'd2;
    localparam logic [4:0] SRC_DOWN    = 5'd3;
    localparam logic [4:0] SRC_LEFT    = 5'd4;
    localparam logic [4:0] SRC_SWITCH0 = 5'd5;

    // Packed MSB-first, so center lands on bit 0 and matches its source id.
    typedef struct packed {
        logic left;
        logic down;
        logic right;
        logic up;
        logic center;
    } buttons_t;

    typedef struct packed {
        logic       level;
        logic [4:0] source;
    } event_t;

endpackage

// File: rtl/input_event_capture_debouncer.sv
// One-bit 2-FF synchroniser followed by a stable-level debounce counter.
module input_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic raw_i,
    output logic level_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Flip after DEBOUNCE_CYCLES+1 consecutive differing synchronised samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == TERM) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/input_event_capture.sv
// Debounces buttons/switches and queues every level change as an event in a FWFT FIFO.
module input_event_capture
    import peripherals::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic                        clock_100mhz,
    input  logic                        reset_n,
    input  buttons_t                    buttons,
    input  logic [15:0]                 switches,
    output logic [4:0]                  buttons_level,
    output logic [15:0]                 switches_level,
    output logic                        event_valid,
    output event_t                      event_data,
    input  logic                        event_ready,
    output logic [$clog2(FIFO_DEPTH):0] event_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [NUM_SOURCES-1:0] raw;
    logic [NUM_SOURCES-1:0] level;
    logic [NUM_SOURCES-1:0] reported_q, reported_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    event_t                 mem_q [FIFO_DEPTH];

    logic       scan_hit;
    logic [4:0] scan_id;
    logic       full, pop, push;
    event_t     push_entry;

    assign raw = {switches, buttons};

    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_deb
        input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i  (clock_100mhz),
            .rst_n_i(reset_n),
            .raw_i  (raw[g]),
            .level_o(level[g])
        );
    end

    assign buttons_level  = level[SRC_CENTER +: 5];
    assign switches_level = level[SRC_SWITCH0 +: 16];

    // Lowest-id pending change wins; a toggle that returns before its turn leaves no difference.
    always_comb begin
        scan_hit = 1'b0;
        scan_id  = '0;
        for (int i = int'(NUM_SOURCES) - 1; i >= 0; i--) begin
            if (level[i] != reported_q[i]) begin
                scan_hit = 1'b1;
                scan_id  = 5'(i);
            end
        end
    end

    assign full       = (count_q == DEPTH_C);
    assign pop        = (count_q != '0) && event_ready;
    assign push       = scan_hit && (!full || pop);
    assign push_entry = '{level: level[scan_id], source: scan_id};

    always_comb begin
        reported_d = reported_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            reported_d[scan_id] = level[scan_id];
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            reported_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            reported_q <= reported_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the queue is empty.
    always_ff @(posedge clock_100mhz) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign event_valid = (count_q != '0);
    assign event_data  = event_valid ? mem_q[rd_ptr_q] : '0;
    assign event_count = count_q;

endmodule

// File: tb/tb_input_event_capture.sv
// Self-checking bench: table-driven level vectors plus scoreboarded event stream.
module tb_input_event_capture;
    import peripherals::*;

    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    buttons_t    buttons;
    logic [15:0] switches;
    logic [4:0]  buttons_level;
    logic [15:0] switches_level;
    logic        event_valid;
    event_t      event_data;
    logic        event_ready;
    logic [2:0]  event_count;

    input_event_capture #(
        .DEBOUNCE_CYCLES(D),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clock_100mhz  (clk),
        .reset_n       (rst_n),
        .buttons       (buttons),
        .switches      (switches),
        .buttons_level (buttons_level),
        .switches_level(switches_level),
        .event_valid   (event_valid),
        .event_data    (event_data),
        .event_ready   (event_ready),
        .event_count   (event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  btn;
        logic [15:0] sw;
        logic [4:0]  exp_btn;
        logic [15:0] exp_sw;
        logic [5:0]  exp_first;
    } vec_t;

    vec_t   vecs [5];
    event_t sb [$];
    int     n_cmp = 0;
    int     n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_diff(input logic [20:0] o, input logic [20:0] n);
        for (int i = 0; i < 21; i++) begin
            if (o[i] != n[i]) sb.push_back('{level: n[i], source: 5'(i)});
        end
    endtask

    task automatic drain(input string name, input int budget);
        int c;
        c = 0;
        event_ready = 1'b1;
        while ((sb.size() > 0 || event_valid) && c < budget) begin
            check({name, "_count_vs_valid"}, 32'(event_count != 0), 32'(event_valid));
            if (event_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s_extra: got event 0x%0h expected none", name, event_data);
                end else begin
                    check({name, "_data"}, 32'(event_data), 32'(sb.pop_front()));
                end
            end
            tick();
            c++;
        end
        event_ready = 1'b0;
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d events outstanding expected 0", name, sb.size());
            sb.delete();
        end
        repeat (2) tick();
        check({name, "_empty_valid"}, 32'(event_valid), 32'd0);
        check({name, "_empty_count"}, 32'(event_count), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [20:0] prev, cur;

        vecs[0] = '{btn: 5'b00010, sw: 16'h0000, exp_btn: 5'b00010, exp_sw: 16'h0000, exp_first: 6'b1_00001};
        vecs[1] = '{btn: 5'b10001, sw: 16'h0001, exp_btn: 5'b10001, exp_sw: 16'h0001, exp_first: 6'b1_00000};
        vecs[2] = '{btn: 5'b00000, sw: 16'h8003, exp_btn: 5'b00000, exp_sw: 16'h8003, exp_first: 6'b0_00000};
        vecs[3] = '{btn: 5'b11111, sw: 16'hFFFF, exp_btn: 5'b11111, exp_sw: 16'hFFFF, exp_first: 6'b1_00000};
        vecs[4] = '{btn: 5'b00000, sw: 16'h0000, exp_btn: 5'b00000, exp_sw: 16'h0000, exp_first: 6'b0_00000};

        rst_n       = 1'b0;
        buttons     = '0;
        switches    = '0;
        event_ready = 1'b0;
        #3;
        check("rst_valid", 32'(event_valid), 32'd0);
        check("rst_data", 32'(event_data), 32'd0);
        check("rst_count", 32'(event_count), 32'd0);
        check("rst_levels", 32'({switches_level, buttons_level}), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;

        prev = '0;
        for (int k = 0; k < 5; k++) begin
            buttons  = buttons_t'(vecs[k].btn);
            switches = vecs[k].sw;
            cur      = {vecs[k].exp_sw, vecs[k].exp_btn};
            push_diff(prev, cur);
            repeat (D + 2) tick();
            check("vec_level_before", 32'({switches_level, buttons_level}), 32'(prev));
            tick();
            check("vec_level_after", 32'({switches_level, buttons_level}), 32'(cur));
            check("vec_valid_before", 32'(event_valid), 32'd0);
            tick();
            check("vec_first_valid", 32'(event_valid), 32'd1);
            check("vec_first_data", 32'(event_data), 32'(vecs[k].exp_first));
            check("vec_first_count", 32'(event_count), 32'd1);
            drain("vec", 200);
            prev = cur;
        end

        // Glitch one cycle short of acceptance.
        switches[3] = 1'b1;
        repeat (D) tick();
        switches[3] = 1'b0;
        repeat (12) tick();
        check("glitch_level", 32'(switches_level), 32'd0);
        check("glitch_valid", 32'(event_valid), 32'd0);

        // Pulse exactly long enough: accepted, then released.
        switches[3] = 1'b1;
        repeat (D + 1) tick();
        switches[3] = 1'b0;
        sb.push_back('{level: 1'b1, source: 5'd8});
        sb.push_back('{level: 1'b0, source: 5'd8});
        drain("pulse", 40);

        // Fill beyond depth with no pops.
        switches = 16'h003F;
        for (int i = 0; i < 6; i++) sb.push_back('{level: 1'b1, source: 5'(5 + i)});
        repeat (D + 3 + 6) tick();
        check("fill_count", 32'(event_count), 32'(DEPTH));
        check("fill_valid", 32'(event_valid), 32'd1);
        check("fill_head", 32'(event_data), 32'(6'b1_00101));
        drain("fill", 40);

        // Collapse: switch 6 rises and falls while the queue is full.
        switches = 16'h0030;
        for (int i = 0; i < 4; i++) sb.push_back('{level: 1'b0, source: 5'(5 + i)});
        repeat (D + 3 + 5) tick();
        check("collapse_full", 32'(event_count), 32'(DEPTH));
        switches = 16'h0070;
        repeat (D + 3 + 2) tick();
        check("collapse_level_hi", 32'(switches_level), 32'h0070);
        switches = 16'h0030;
        repeat (D + 3 + 2) tick();
        check("collapse_level_lo", 32'(switches_level), 32'h0030);
        check("collapse_still_full", 32'(event_count), 32'(DEPTH));
        drain("collapse", 40);

        // Asynchronous reset with three queued events.
        buttons = buttons_t'(5'b00111);
        repeat (D + 6) tick();
        check("prereset_count", 32'(event_count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", 32'(event_valid), 32'd0);
        check("areset_count", 32'(event_count), 32'd0);
        check("areset_data", 32'(event_data), 32'd0);
        check("areset_levels", 32'({switches_level, buttons_level}), 32'd0);
        tick();
        rst_n = 1'b1;
        sb.push_back('{level: 1'b1, source: 5'd0});
        sb.push_back('{level: 1'b1, source: 5'd1});
        sb.push_back('{level: 1'b1, source: 5'd2});
        sb.push_back('{level: 1'b1, source: 5'd9});
        sb.push_back('{level: 1'b1, source: 5'd10});
        drain("post_reset", 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
